// File: rtl/flow_ctrl.sv
// flow_ctrl: front-end pipeline sequencer; sole owner of pc_reg, IF/ID and ID/EX flow commands.
// Ports: clk, rst_n, jtag/div/jump/load-use/irq requests in; flow cmds, next PC, irq_ack, epc, halted out.
module flow_ctrl #(
  parameter int CPU_WIDTH    = 32,
  parameter int FLOW_WIDTH   = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jtag_reset_flag_i,
  input  logic                  jtag_halt_req_i,
  input  logic                  div_busy_i,
  input  logic                  jump_req_i,
  input  logic [CPU_WIDTH-1:0]  jump_addr_i,
  input  logic                  load_use_i,
  input  logic                  irq_req_i,
  input  logic                  irq_en_i,
  input  logic [CPU_WIDTH-1:0]  irq_vec_i,
  input  logic [CPU_WIDTH-1:0]  ex_pc_i,
  output logic [FLOW_WIDTH-1:0] flow_pc_o,
  output logic                  next_pc_four_o,
  output logic [CPU_WIDTH-1:0]  next_pc_o,
  output logic [FLOW_WIDTH-1:0] flow_if_id_o,
  output logic [FLOW_WIDTH-1:0] flow_id_ex_o,
  output logic                  irq_ack_o,
  output logic [CPU_WIDTH-1:0]  epc_o,
  output logic                  halted_o
);

  localparam logic [FLOW_WIDTH-1:0] F_WORK = FLOW_WIDTH'(0);
  localparam logic [FLOW_WIDTH-1:0] F_STOP = FLOW_WIDTH'(1);
  localparam logic [FLOW_WIDTH-1:0] F_RFSH = FLOW_WIDTH'(2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       epc_ld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
      epc_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (epc_ld) epc_o <= ex_pc_i;
    end
  end

  always_comb begin
    flow_pc_o      = F_WORK;
    flow_if_id_o   = F_WORK;
    flow_id_ex_o   = F_WORK;
    next_pc_four_o = 1'b1;
    next_pc_o      = jump_addr_i;
    irq_ack_o      = 1'b0;
    halted_o       = 1'b0;
    state_nxt      = state;
    cnt_nxt        = cnt;
    epc_ld         = 1'b0;
    if (!rst_n) begin
      flow_pc_o    = F_STOP;
      flow_if_id_o = F_RFSH;
      flow_id_ex_o = F_RFSH;
      next_pc_o    = '0;
    end else if (jtag_reset_flag_i) begin
      // pc_reg clears itself on debug reset, so hold it rather than redirect
      flow_pc_o    = F_STOP;
      flow_if_id_o = F_RFSH;
      flow_id_ex_o = F_RFSH;
      state_nxt    = RUN;
      cnt_nxt      = 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (div_busy_i) begin
            flow_pc_o    = F_STOP;
            flow_if_id_o = F_STOP;
            flow_id_ex_o = F_STOP;
          end else if (jump_req_i) begin
            next_pc_four_o = 1'b0;
            flow_if_id_o   = F_RFSH;
            flow_id_ex_o   = F_RFSH;
          end else if (irq_req_i && irq_en_i) begin
            next_pc_four_o = 1'b0;
            next_pc_o      = irq_vec_i;
            flow_if_id_o   = F_RFSH;
            flow_id_ex_o   = F_RFSH;
            irq_ack_o      = 1'b1;
            epc_ld         = 1'b1;
          end else if (load_use_i) begin
            flow_pc_o    = F_STOP;
            flow_if_id_o = F_STOP;
            flow_id_ex_o = F_RFSH;
          end
          // the current cycle's decode still completes before draining
          if (jtag_halt_req_i) begin
            state_nxt = DRAIN;
            cnt_nxt   = 4'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          flow_pc_o    = F_STOP;
          flow_if_id_o = F_RFSH;
          if (div_busy_i) begin
            flow_id_ex_o = F_STOP;
          end else begin
            if (jump_req_i) begin
              flow_pc_o      = F_WORK;
              next_pc_four_o = 1'b0;
              flow_id_ex_o   = F_RFSH;
            end
            // cnt==0 cannot occur here; treated as expired for safety
            if (cnt <= 4'd1) begin
              state_nxt = HALTED;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end
        end
        HALTED: begin
          flow_pc_o    = F_STOP;
          flow_if_id_o = F_RFSH;
          flow_id_ex_o = F_RFSH;
          halted_o     = 1'b1;
          if (!jtag_halt_req_i) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed self-checking bench for flow_ctrl.
// Inputs change on negedge; outputs are checked 2ns later.
module tb_flow_ctrl;

  localparam logic [1:0] W = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] R = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jtag_reset_flag_i;
  logic        jtag_halt_req_i;
  logic        div_busy_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        load_use_i;
  logic        irq_req_i;
  logic        irq_en_i;
  logic [31:0] irq_vec_i;
  logic [31:0] ex_pc_i;
  logic [1:0]  flow_pc_o;
  logic        next_pc_four_o;
  logic [31:0] next_pc_o;
  logic [1:0]  flow_if_id_o;
  logic [1:0]  flow_id_ex_o;
  logic        irq_ack_o;
  logic [31:0] epc_o;
  logic        halted_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flow_ctrl #(.CPU_WIDTH(32), .FLOW_WIDTH(2), .DRAIN_CYCLES(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .jtag_reset_flag_i(jtag_reset_flag_i),
    .jtag_halt_req_i  (jtag_halt_req_i),
    .div_busy_i       (div_busy_i),
    .jump_req_i       (jump_req_i),
    .jump_addr_i      (jump_addr_i),
    .load_use_i       (load_use_i),
    .irq_req_i        (irq_req_i),
    .irq_en_i         (irq_en_i),
    .irq_vec_i        (irq_vec_i),
    .ex_pc_i          (ex_pc_i),
    .flow_pc_o        (flow_pc_o),
    .next_pc_four_o   (next_pc_four_o),
    .next_pc_o        (next_pc_o),
    .flow_if_id_o     (flow_if_id_o),
    .flow_id_ex_o     (flow_id_ex_o),
    .irq_ack_o        (irq_ack_o),
    .epc_o            (epc_o),
    .halted_o         (halted_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flow(input string tag, input logic [1:0] pc,
                          input logic [1:0] ifid, input logic [1:0] idex);
    chk({tag, ".pc"}, 32'(flow_pc_o), 32'(pc));
    chk({tag, ".if_id"}, 32'(flow_if_id_o), 32'(ifid));
    chk({tag, ".id_ex"}, 32'(flow_id_ex_o), 32'(idex));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    jtag_reset_flag_i = 1'b0;
    jtag_halt_req_i = 1'b0;
    div_busy_i = 1'b0;
    jump_req_i = 1'b0;
    jump_addr_i = 32'h1234;
    load_use_i = 1'b0;
    irq_req_i = 1'b0;
    irq_en_i = 1'b0;
    irq_vec_i = 32'h0;
    ex_pc_i = 32'h0;

    // reset
    step(); settle();
    chk_flow("rst", S, R, R);
    chk("rst.npf", 32'(next_pc_four_o), 32'd1);
    chk("rst.npc", next_pc_o, 32'h0);
    chk("rst.ack", 32'(irq_ack_o), 32'd0);
    chk("rst.halted", 32'(halted_o), 32'd0);
    step(); settle();
    chk("rst.epc", epc_o, 32'h0);

    // idle
    step(); rst_n = 1'b1; jump_addr_i = 32'h0; settle();
    chk_flow("idle", W, W, W);
    chk("idle.npf", 32'(next_pc_four_o), 32'd1);
    chk("idle.halted", 32'(halted_o), 32'd0);

    // jump
    step(); jump_req_i = 1'b1; jump_addr_i = 32'h100; settle();
    chk_flow("jmp", W, R, R);
    chk("jmp.npf", 32'(next_pc_four_o), 32'd0);
    chk("jmp.npc", next_pc_o, 32'h100);
    step(); jump_req_i = 1'b0; settle();
    chk_flow("jmp2", W, W, W);
    chk("jmp2.npf", 32'(next_pc_four_o), 32'd1);

    // irq masked
    step(); irq_req_i = 1'b1; irq_en_i = 1'b0; settle();
    chk_flow("irqoff", W, W, W);
    chk("irqoff.ack", 32'(irq_ack_o), 32'd0);

    // jump beats irq
    step();
    irq_en_i = 1'b1; irq_vec_i = 32'h80; ex_pc_i = 32'h44;
    jump_req_i = 1'b1; jump_addr_i = 32'h200;
    settle();
    chk("pri.npc", next_pc_o, 32'h200);
    chk("pri.ack", 32'(irq_ack_o), 32'd0);
    step(); jump_req_i = 1'b0; settle();
    chk("pri.epc_hold", epc_o, 32'h0);
    chk_flow("irq", W, R, R);
    chk("irq.npf", 32'(next_pc_four_o), 32'd0);
    chk("irq.npc", next_pc_o, 32'h80);
    chk("irq.ack", 32'(irq_ack_o), 32'd1);
    step(); irq_req_i = 1'b0; ex_pc_i = 32'h0; settle();
    chk("irq.epc", epc_o, 32'h44);
    chk("irq.ack_off", 32'(irq_ack_o), 32'd0);

    // divider stall overrides load-use and irq
    for (int i = 0; i < 5; i++) begin
      step();
      div_busy_i = 1'b1; load_use_i = 1'b1; irq_req_i = 1'b1;
      settle();
      chk_flow($sformatf("div%0d", i), S, S, S);
      chk($sformatf("div%0d.ack", i), 32'(irq_ack_o), 32'd0);
    end
    step(); div_busy_i = 1'b0; irq_req_i = 1'b0; settle();
    chk_flow("lu", S, S, R);
    step(); load_use_i = 1'b0; settle();
    chk_flow("lu_end", W, W, W);
    chk("div.epc", epc_o, 32'h44);

    // halt with 2 div-busy cycles inside drain
    step(); jtag_halt_req_i = 1'b1; settle();
    chk_flow("h0", W, W, W);
    chk("h0.halted", 32'(halted_o), 32'd0);
    for (int i = 1; i <= 2; i++) begin
      step(); div_busy_i = 1'b1; settle();
      chk_flow($sformatf("h%0d", i), S, R, S);
      chk($sformatf("h%0d.halted", i), 32'(halted_o), 32'd0);
    end
    step(); div_busy_i = 1'b0; irq_req_i = 1'b1; ex_pc_i = 32'h55; settle();
    chk_flow("h3", S, R, W);
    chk("h3.ack", 32'(irq_ack_o), 32'd0);
    chk("h3.halted", 32'(halted_o), 32'd0);
    step(); settle();
    chk("h4.halted", 32'(halted_o), 32'd0);
    step(); settle();
    chk("h5.halted", 32'(halted_o), 32'd0);
    step(); settle();
    chk("h6.halted", 32'(halted_o), 32'd1);
    chk_flow("h6", S, R, R);
    chk("h6.ack", 32'(irq_ack_o), 32'd0);
    step(); jtag_halt_req_i = 1'b0; irq_req_i = 1'b0; settle();
    chk("h7.halted", 32'(halted_o), 32'd1);
    step(); settle();
    chk("h8.halted", 32'(halted_o), 32'd0);
    chk_flow("h8", W, W, W);
    chk("h8.epc", epc_o, 32'h44);

    // jump in drain, then debug reset mid-drain
    step(); jtag_halt_req_i = 1'b1; settle();
    chk_flow("d0", W, W, W);
    step(); jump_req_i = 1'b1; jump_addr_i = 32'h300; settle();
    chk_flow("djmp", W, R, R);
    chk("djmp.npf", 32'(next_pc_four_o), 32'd0);
    chk("djmp.npc", next_pc_o, 32'h300);
    step();
    jump_req_i = 1'b0; jtag_reset_flag_i = 1'b1;
    irq_req_i = 1'b1; ex_pc_i = 32'h99;
    settle();
    chk_flow("jrst", S, R, R);
    chk("jrst.ack", 32'(irq_ack_o), 32'd0);
    chk("jrst.halted", 32'(halted_o), 32'd0);
    step();
    jtag_reset_flag_i = 1'b0; jtag_halt_req_i = 1'b0; irq_req_i = 1'b0;
    settle();
    chk_flow("jrst2", W, W, W);
    chk("jrst2.npf", 32'(next_pc_four_o), 32'd1);
    chk("jrst2.halted", 32'(halted_o), 32'd0);
    chk("jrst2.epc", epc_o, 32'h44);

    // debug reset in RUN blocks irq and keeps epc
    step(); irq_req_i = 1'b1; jtag_reset_flag_i = 1'b1; settle();
    chk_flow("jrun", S, R, R);
    chk("jrun.ack", 32'(irq_ack_o), 32'd0);
    step(); irq_req_i = 1'b0; jtag_reset_flag_i = 1'b0; settle();
    chk("jrun.epc", epc_o, 32'h44);
    chk_flow("jrun2", W, W, W);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
